// File: rtl/shift_mode_ctrl.sv
// Sequencing controller for a pulsed-latch multi-mode shift register.
// Drives the shared sel bus, then issues non-overlapping enable pulses on En1 or En2.
module shift_mode_ctrl #(
    parameter int WIDTH   = 8,
    parameter int CNT_W   = 4,
    parameter int PULSE_W = 1,
    parameter int GAP_W   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_mode,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic             abort,
    output logic [2:0]       sel,
    output logic             En1,
    output logic             En2,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] pulses_left
);

    localparam int TMR_MAX = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
    localparam int TMR_W   = $clog2(TMR_MAX) + 1;
    localparam logic [TMR_W-1:0] PULSE_LAST = TMR_W'(PULSE_W - 1);
    localparam logic [TMR_W-1:0] GAP_LAST   = TMR_W'(GAP_W - 1);
    localparam logic [CNT_W-1:0] MAX_CNT    = CNT_W'(WIDTH);
    localparam logic [2:0]       MODE_LOAD  = 3'b010;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_PULSE,
        S_GAP,
        S_DONE
    } state_t;

    function automatic logic is_illegal(input logic [2:0] m);
        return (m > 3'b100);
    endfunction

    // Clamp to the register depth; a parallel load only ever needs one pulse.
    function automatic logic [CNT_W-1:0] eff_count(input logic [2:0] m,
                                                   input logic [CNT_W-1:0] c);
        logic [CNT_W-1:0] n;
        n = (c > MAX_CNT) ? MAX_CNT : c;
        if ((m == MODE_LOAD) && (n != '0)) begin
            n = CNT_W'(1);
        end
        return n;
    endfunction

    state_t             state_q, state_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [CNT_W-1:0]   left_q,  left_d;
    logic [2:0]         mode_q,  mode_d;
    logic               en1_q,   en1_d;
    logic               en2_q,   en2_d;
    logic               busy_q,  busy_d;
    logic               done_q,  done_d;
    logic               err_q,   err_d;
    logic               ready_q, ready_d;
    logic [CNT_W-1:0]   accept_cnt;

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        left_d     = left_q;
        mode_d     = mode_q;
        err_d      = 1'b0;
        accept_cnt = eff_count(cmd_mode, cmd_count);

        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid && ready_q) begin
                    if (is_illegal(cmd_mode)) begin
                        err_d = 1'b1;
                    end else begin
                        mode_d  = cmd_mode;
                        left_d  = accept_cnt;
                        timer_d = '0;
                        state_d = (accept_cnt == '0) ? S_DONE : S_SETUP;
                    end
                end
            end
            S_SETUP: begin
                timer_d = '0;
                state_d = S_PULSE;
            end
            S_PULSE: begin
                if (timer_q == PULSE_LAST) begin
                    left_d  = left_q - CNT_W'(1);
                    timer_d = '0;
                    state_d = S_GAP;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            S_GAP: begin
                if (timer_q == GAP_LAST) begin
                    timer_d = '0;
                    state_d = (left_q != '0) ? S_PULSE : S_DONE;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort wins over normal progress but leaves sel where it is.
        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            left_d  = '0;
            timer_d = '0;
        end

        // Outputs are registered copies of what the next state implies.
        en1_d   = (state_d == S_PULSE) && (mode_d != MODE_LOAD);
        en2_d   = (state_d == S_PULSE) && (mode_d == MODE_LOAD);
        busy_d  = (state_d != S_IDLE);
        done_d  = (state_d == S_DONE);
        ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            left_q  <= '0;
            mode_q  <= 3'b000;
            en1_q   <= 1'b0;
            en2_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            left_q  <= left_d;
            mode_q  <= mode_d;
            en1_q   <= en1_d;
            en2_q   <= en2_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            ready_q <= ready_d;
        end
    end

    assign cmd_ready   = ready_q;
    assign sel         = mode_q;
    assign En1         = en1_q;
    assign En2         = en2_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;
    assign pulses_left = left_q;

endmodule
